// File: rtl/rgb_pixel_assembler_if.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pixel_assembler_if
// Brief    : Stream-side bundle of the RGB pixel assembler: parser byte
//            stream and dimensions in, tagged pixels out.
// Revision : 1.0 - initial release
// ============================================================================
interface rgb_pixel_assembler_if #(
  parameter int XW = 16,
  parameter int YW = 16
);
  // Parser side
  logic          i_pxq;
  logic          i_rgb_valid;
  logic [7:0]    i_d_in;
  logic          i_dimensions_valid;
  logic [31:0]   i_line_width;
  logic [31:0]   i_pic_height;
  // Pixel side
  logic          o_pix_valid;
  logic [7:0]    o_pix_r;
  logic [7:0]    o_pix_g;
  logic [7:0]    o_pix_b;
  logic [XW-1:0] o_pix_x;
  logic [YW-1:0] o_pix_y;
  logic          o_line_start;
  logic          o_line_end;
  logic          o_frame_end;
  logic          o_frame_err;

  // The assembler itself
  modport slave (
    input  i_pxq, i_rgb_valid, i_d_in, i_dimensions_valid, i_line_width, i_pic_height,
    output o_pix_valid, o_pix_r, o_pix_g, o_pix_b, o_pix_x, o_pix_y,
           o_line_start, o_line_end, o_frame_end, o_frame_err
  );

  // Whatever drives the byte stream and consumes pixels
  modport master (
    output i_pxq, i_rgb_valid, i_d_in, i_dimensions_valid, i_line_width, i_pic_height,
    input  o_pix_valid, o_pix_r, o_pix_g, o_pix_b, o_pix_x, o_pix_y,
           o_line_start, o_line_end, o_frame_end, o_frame_err
  );
endinterface
`default_nettype wire

// File: rtl/rgb_pixel_assembler.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pixel_assembler
// Brief    : Packs R,G,B byte triples from the imager parser into pixels and
//            tags them with raster x/y, line start/end and frame end.
//            Optional macro FRAME_CHECK_EN builds the sticky frame_err
//            detector (overrun in DONE, frame truncated while ACTIVE).
// Revision : 1.0 - initial release
// ============================================================================
module rgb_pixel_assembler #(
  parameter int XW = 16,
  parameter int YW = 16
) (
  input  wire logic               clk_in,
  input  wire logic               rst,
  rgb_pixel_assembler_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [1:0]    r_phase;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [XW-1:0] r_w;
  logic [YW-1:0] r_h;
  logic [7:0]    r_r;
  logic [7:0]    r_g;

  logic          r_pix_valid;
  logic [7:0]    r_pix_r;
  logic [7:0]    r_pix_g;
  logic [7:0]    r_pix_b;
  logic [XW-1:0] r_pix_x;
  logic [YW-1:0] r_pix_y;
  logic          r_line_start;
  logic          r_line_end;
  logic          r_frame_end;
  logic          r_frame_err;

  logic [XW-1:0] w_dim_w;
  logic [YW-1:0] w_dim_h;
  logic          w_dims_zero;
  logic          w_x_last;
  logic          w_y_last;
  logic          w_latch;
  logic          w_take_r;
  logic          w_take_g;
  logic          w_emit;
  logic          w_abort;
  logic          w_unused;

  // Only the low XW/YW bits of the parser's dimension words are meaningful
  assign w_dim_w     = bus.i_line_width[XW-1:0];
  assign w_dim_h     = bus.i_pic_height[YW-1:0];
  assign w_unused    = ^{bus.i_line_width[31:XW], bus.i_pic_height[31:YW]};
  assign w_dims_zero = (w_dim_w == '0) || (w_dim_h == '0);
  assign w_x_last    = (r_x == r_w - XW'(1));
  assign w_y_last    = (r_y == r_h - YW'(1));

  // FSM state register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and per-cycle datapath controls; pxq low overrides all
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_take_r    = 1'b0;
    w_take_g    = 1'b0;
    w_emit      = 1'b0;
    w_abort     = 1'b0;
    if (!bus.i_pxq) begin
      w_state_nxt = S_IDLE;
      w_abort     = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_rgb_valid && bus.i_dimensions_valid) begin
            w_latch = 1'b1;
            if (w_dims_zero) begin
              w_state_nxt = S_DONE;
            end else begin
              w_take_r    = 1'b1;
              w_state_nxt = S_ACTIVE;
            end
          end
        end
        S_ACTIVE: begin
          if (bus.i_rgb_valid) begin
            case (r_phase)
              2'd0:    w_take_r = 1'b1;
              2'd1:    w_take_g = 1'b1;
              default: begin
                w_emit = 1'b1;
                if (w_x_last && w_y_last) w_state_nxt = S_DONE;
              end
            endcase
          end
        end
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Dimension latch, byte phase, held R/G and raster coordinates
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_w     <= '0;
      r_h     <= '0;
      r_phase <= 2'd0;
      r_x     <= '0;
      r_y     <= '0;
      r_r     <= 8'd0;
      r_g     <= 8'd0;
    end else begin
      if (w_latch) begin
        r_w <= w_dim_w;
        r_h <= w_dim_h;
      end
      if (w_abort) begin
        r_phase <= 2'd0;
        r_x     <= '0;
        r_y     <= '0;
      end else if (w_take_r) begin
        r_r     <= bus.i_d_in;
        r_phase <= 2'd1;
      end else if (w_take_g) begin
        r_g     <= bus.i_d_in;
        r_phase <= 2'd2;
      end else if (w_emit) begin
        r_phase <= 2'd0;
        // Last pixel of the frame leaves x,y where they are
        if (!(w_x_last && w_y_last)) begin
          if (w_x_last) begin
            r_x <= '0;
            r_y <= r_y + YW'(1);
          end else begin
            r_x <= r_x + XW'(1);
          end
        end
      end
    end
  end

  // Registered pixel outputs; strobes pulse only in the cycle after the B byte
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_pix_valid  <= 1'b0;
      r_pix_r      <= 8'd0;
      r_pix_g      <= 8'd0;
      r_pix_b      <= 8'd0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_line_start <= 1'b0;
      r_line_end   <= 1'b0;
      r_frame_end  <= 1'b0;
    end else begin
      r_pix_valid  <= w_emit;
      r_line_start <= w_emit && (r_x == '0);
      r_line_end   <= w_emit && w_x_last;
      r_frame_end  <= w_emit && w_x_last && w_y_last;
      if (w_emit) begin
        r_pix_r <= r_r;
        r_pix_g <= r_g;
        r_pix_b <= bus.i_d_in;
        r_pix_x <= r_x;
        r_pix_y <= r_y;
      end
    end
  end

`ifdef FRAME_CHECK_EN
  logic w_overrun;
  logic w_truncate;
  logic w_start;

  assign w_overrun  = bus.i_pxq && bus.i_rgb_valid && (r_state == S_DONE);
  assign w_truncate = !bus.i_pxq && (r_state == S_ACTIVE);
  assign w_start    = (r_state == S_IDLE) && (w_state_nxt == S_ACTIVE);

  // Sticky stream error, cleared when a new frame starts
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)                         r_frame_err <= 1'b0;
    else if (w_start)                r_frame_err <= 1'b0;
    else if (w_overrun || w_truncate) r_frame_err <= 1'b1;
  end
`else
  assign r_frame_err = 1'b0;
`endif

  assign bus.o_pix_valid  = r_pix_valid;
  assign bus.o_pix_r      = r_pix_r;
  assign bus.o_pix_g      = r_pix_g;
  assign bus.o_pix_b      = r_pix_b;
  assign bus.o_pix_x      = r_pix_x;
  assign bus.o_pix_y      = r_pix_y;
  assign bus.o_line_start = r_line_start;
  assign bus.o_line_end   = r_line_end;
  assign bus.o_frame_end  = r_frame_end;
  assign bus.o_frame_err  = r_frame_err;

endmodule
`default_nettype wire
